// File: rtl/nios2_mul_pkg.sv
// Shared types and helpers for the sequenced 32x32 multiply path.
// Holds the FSM state encoding and the partial-product combine function.
package nios2_mul_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        COMBINE = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Low word of A*B from three partial products. The hi*hi term and the
    // upper halves of the cross products only land above bit 31, so they
    // are dropped; the 16-bit cross sum wraps harmlessly once shifted.
    function automatic logic [WORD_W-1:0] mul_combine(
        input logic [WORD_W-1:0] p1,
        input logic [WORD_W-1:0] p2,
        input logic [WORD_W-1:0] p3
    );
        logic [HALF_W-1:0] mid;
        mid = p2[HALF_W-1:0] + p3[HALF_W-1:0];
        return p1 + {mid, {HALF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/nios2_cpu_mul_seq.sv
// Request/response sequencer for the three-partial-product multiplier cell.
// Captures one operation, drives the cell, combines its products, returns the result.
module nios2_cpu_mul_seq
    import nios2_mul_pkg::*;
#(
    parameter int CELL_LATENCY = 1,
    parameter int TAG_W        = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_src1,
    input  logic [31:0]       req_src2,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              flush,
    output logic [31:0]       cell_src1,
    output logic [31:0]       cell_src2,
    output logic              cell_en,
    input  logic [31:0]       cell_p1,
    input  logic [31:0]       cell_p2,
    input  logic [31:0]       cell_p3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
);

    localparam int CNT_W     = $clog2(CELL_LATENCY + 1);
    localparam int WAIT_LAST = (CELL_LATENCY > 1) ? CELL_LATENCY - 2 : 0;

    state_t             state, state_n;
    logic [WORD_W-1:0]  src1_q, src2_q, result_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               accept, zero_op;

    // flush takes priority over a same-cycle request accept
    assign accept  = req_valid && (state == IDLE) && !flush;
    assign zero_op = (req_src1 == '0) || (req_src2 == '0);

    always_comb begin
        state_n = state;
        cell_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_n = zero_op ? RESP : ISSUE;
            end
            ISSUE: begin
                cell_en = 1'b1;
                state_n = (CELL_LATENCY > 1) ? WAIT : COMBINE;
            end
            WAIT: begin
                cell_en = 1'b1;
                if (wait_cnt == CNT_W'(WAIT_LAST)) state_n = COMBINE;
            end
            COMBINE: state_n = RESP;
            RESP: begin
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            src1_q   <= '0;
            src2_q   <= '0;
            tag_q    <= '0;
            result_q <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (accept) begin
                src1_q <= req_src1;
                src2_q <= req_src2;
                tag_q  <= req_tag;
                if (zero_op) result_q <= '0;
            end
            if (state == COMBINE && !flush)
                result_q <= mul_combine(cell_p1, cell_p2, cell_p3);
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);
    assign rsp_result = result_q;
    assign rsp_tag    = tag_q;
    assign cell_src1  = src1_q;
    assign cell_src2  = src2_q;

endmodule
